// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS-subset core (IF, ID, EX, MEM, WB) over one word-addressed memory.
// Optional multiplier: define MIPS_MUL_EN to make opcode 000101 a signed MUL; otherwise it is a NOP.
module pipe_mips32 #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic clk1,
    input  logic rst,
    output logic halted
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_AND  = 6'h02, OP_OR   = 6'h03,
                           OP_SLT  = 6'h04, OP_MUL  = 6'h05, OP_LW   = 6'h08, OP_SW   = 6'h09,
                           OP_ADDI = 6'h0A, OP_SUBI = 6'h0B, OP_SLTI = 6'h0C, OP_BNEZ = 6'h0D,
                           OP_BEQZ = 6'h0E, OP_HLT  = 6'h3F;

    typedef struct packed {
        logic        v;
        logic [31:0] ir;
        logic [31:0] npc;
    } fd_t;

    typedef struct packed {
        logic        v;
        logic [5:0]  op;
        logic [4:0]  rs, rt, dst;
        logic        wen, hlt;
        logic [31:0] a, b, imm, npc;
    } de_t;

    typedef struct packed {
        logic        v, wen, lw, sw, hlt;
        logic [4:0]  dst;
        logic [31:0] res, b;
    } em_t;

    typedef struct packed {
        logic        v, wen, hlt;
        logic [4:0]  dst;
        logic [31:0] val;
    } mw_t;

    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:MEM_DEPTH-1];

    logic [31:0] pc;
    logic        fetch_stop;
    fd_t fd;
    de_t de;
    em_t em;
    mw_t mw;

    // decode
    logic [5:0]  d_op;
    logic [4:0]  d_rs, d_rt, d_rd, d_dst;
    logic [31:0] d_imm, d_a, d_b;
    logic        d_rr, d_ri, d_wen, id_hlt, wb_we;

    assign d_op  = fd.ir[31:26];
    assign d_rs  = fd.ir[25:21];
    assign d_rt  = fd.ir[20:16];
    assign d_rd  = fd.ir[15:11];
    assign d_imm = {{16{fd.ir[15]}}, fd.ir[15:0]};
`ifdef MIPS_MUL_EN
    assign d_rr  = (d_op <= OP_MUL);
`else
    assign d_rr  = (d_op <= OP_SLT);
`endif
    assign d_ri  = (d_op == OP_ADDI) || (d_op == OP_SUBI) || (d_op == OP_SLTI);
    assign d_wen = d_rr || d_ri || (d_op == OP_LW);
    assign d_dst = d_rr ? d_rd : d_rt;
    assign id_hlt = fd.v && (d_op == OP_HLT);

    // WB writes in the same cycle are visible to the ID read
    assign wb_we = mw.v && mw.wen && (mw.dst != 5'd0) && !halted;
    assign d_a = (d_rs == 5'd0) ? 32'd0 : (wb_we && mw.dst == d_rs) ? mw.val : Reg[d_rs];
    assign d_b = (d_rt == 5'd0) ? 32'd0 : (wb_we && mw.dst == d_rt) ? mw.val : Reg[d_rt];

    // execute with forwarding; loads in EX/MEM have no data yet and are skipped
    logic        em_fwd, mw_fwd, taken;
    logic [31:0] e_a, e_b, alu, target;

    assign em_fwd = em.v && em.wen && !em.lw && (em.dst != 5'd0);
    assign mw_fwd = mw.v && mw.wen && (mw.dst != 5'd0);
    assign e_a = (em_fwd && em.dst == de.rs) ? em.res : (mw_fwd && mw.dst == de.rs) ? mw.val : de.a;
    assign e_b = (em_fwd && em.dst == de.rt) ? em.res : (mw_fwd && mw.dst == de.rt) ? mw.val : de.b;
    assign taken  = de.v && (((de.op == OP_BNEZ) && (e_a != 32'd0)) ||
                             ((de.op == OP_BEQZ) && (e_a == 32'd0)));
    assign target = de.npc + de.imm;

    always_comb begin
        alu = '0;
        case (de.op)
            OP_ADD:                alu = e_a + e_b;
            OP_SUB:                alu = e_a - e_b;
            OP_AND:                alu = e_a & e_b;
            OP_OR:                 alu = e_a | e_b;
            OP_SLT:                alu = {31'd0, $signed(e_a) < $signed(e_b)};
`ifdef MIPS_MUL_EN
            OP_MUL:                alu = e_a * e_b;
`endif
            OP_ADDI, OP_LW, OP_SW: alu = e_a + de.imm;
            OP_SUBI:               alu = e_a - de.imm;
            OP_SLTI:               alu = {31'd0, $signed(e_a) < $signed(de.imm)};
            default:               alu = '0;
        endcase
    end

    logic [31:0] m_rdata;
    assign m_rdata = Mem[em.res[AW-1:0]];

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pc         <= '0;
            fetch_stop <= 1'b0;
            halted     <= 1'b0;
            fd         <= '0;
            de         <= '0;
            em         <= '0;
            mw         <= '0;
        end else if (!halted) begin
            if (mw.v && mw.hlt) halted <= 1'b1;
            mw <= '{v: em.v, wen: em.wen, hlt: em.hlt, dst: em.dst,
                    val: em.lw ? m_rdata : em.res};
            em <= '{v: de.v, wen: de.wen, lw: de.op == OP_LW, sw: de.op == OP_SW,
                    hlt: de.hlt, dst: de.dst, res: alu, b: e_b};
            de <= '{v: fd.v && !taken, op: d_op, rs: d_rs, rt: d_rt, dst: d_dst,
                    wen: d_wen, hlt: d_op == OP_HLT, a: d_a, b: d_b, imm: d_imm, npc: fd.npc};
            // a taken branch outranks a HLT sitting in its shadow
            if (taken) begin
                pc   <= target;
                fd.v <= 1'b0;
            end else if (fetch_stop || id_hlt) begin
                fd.v <= 1'b0;
                if (id_hlt) fetch_stop <= 1'b1;
            end else begin
                fd <= '{v: 1'b1, ir: Mem[pc[AW-1:0]], npc: pc + 32'd1};
                pc <= pc + 32'd1;
            end
        end
    end

    // architectural arrays are not reset so they can be preloaded
    always_ff @(posedge clk1) begin
        if (em.v && em.sw && !halted) Mem[em.res[AW-1:0]] <= em.b;
    end

    always_ff @(posedge clk1) begin
        if (wb_we) Reg[mw.dst] <= mw.val;
    end
endmodule

// File: tb/tb_pipe_mips32.sv
// Bench for pipe_mips32: directed programs with literal results plus random programs
// checked against an instruction-level interpreter and its predicted halt edge.
module tb_pipe_mips32;
    localparam int MD = 1024;
    localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, AND_ = 6'h02, OR_ = 6'h03, SLT = 6'h04,
                           MUL = 6'h05, LW = 6'h08, SW = 6'h09, ADDI = 6'h0A, SUBI = 6'h0B,
                           SLTI = 6'h0C, BNEZ = 6'h0D, BEQZ = 6'h0E, HLT = 6'h3F, NOPOP = 6'h10;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    logic halted;

    pipe_mips32 #(.MEM_DEPTH(MD)) dut (.clk1(clk1), .rst(rst), .halted(halted));

    always #5 clk1 = ~clk1;

    int ncmp = 0, nerr = 0;
    int edge_cnt = 0, exp_edge = 0;
    bit running = 1'b0;

    logic [31:0] init_reg [0:31];
    logic [31:0] init_mem [0:MD-1];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_mem [0:MD-1];

    always @(posedge clk1) if (running) edge_cnt++;

    // halted must be low strictly before the predicted edge and high from it on
    always @(negedge clk1) begin
        if (running) begin
            ncmp++;
            if (halted !== (edge_cnt >= exp_edge)) begin
                nerr++;
                $display("FAIL halted_timing at edge %0d: got %b want %b", edge_cnt, halted,
                         edge_cnt >= exp_edge);
            end
        end
    end

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd, rs, rt);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt, rs,
                                       input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clear_state();
        for (int k = 0; k < 32; k++) init_reg[k] = k;
        for (int k = 0; k < MD; k++) init_mem[k] = '0;
    endtask

    task automatic mset(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_reg[r] = v;
    endtask

    // sequential ISA interpreter; each retired instruction costs one cycle, each taken branch two more
    task automatic model_run(output int exp);
        logic [31:0] pcm, ir, a, b, imm, ea, nxt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        int n, tk;
        for (int k = 0; k < 32; k++) m_reg[k] = init_reg[k];
        m_reg[0] = '0;
        for (int k = 0; k < MD; k++) m_mem[k] = init_mem[k];
        pcm = '0; n = 0; tk = 0;
        for (int s = 0; s < 5000; s++) begin
            ir  = m_mem[pcm[9:0]];
            n++;
            op  = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
            imm = {{16{ir[15]}}, ir[15:0]};
            a   = m_reg[rs]; b = m_reg[rt];
            ea  = a + imm;
            nxt = pcm + 32'd1;
            if (op == HLT) break;
            case (op)
                ADD:  mset(rd, a + b);
                SUB:  mset(rd, a - b);
                AND_: mset(rd, a & b);
                OR_:  mset(rd, a | b);
                SLT:  mset(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
`ifdef MIPS_MUL_EN
                MUL:  mset(rd, a * b);
`endif
                ADDI: mset(rt, a + imm);
                SUBI: mset(rt, a - imm);
                SLTI: mset(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
                LW:   mset(rt, m_mem[ea[9:0]]);
                SW:   m_mem[ea[9:0]] = b;
                BNEZ: if (a != 0) begin nxt = pcm + 32'd1 + imm; tk++; end
                BEQZ: if (a == 0) begin nxt = pcm + 32'd1 + imm; tk++; end
                default: ;
            endcase
            pcm = nxt;
        end
        exp = n + 4 + 2 * tk;
    endtask

    task automatic load_dut();
        rst = 1'b1;
        for (int k = 0; k < 32; k++) dut.Reg[k] = init_reg[k];
        for (int k = 0; k < MD; k++) dut.Mem[k] = init_mem[k];
    endtask

    task automatic go(input string nm);
        @(negedge clk1);
        rst = 1'b0;
        edge_cnt = 0;
        #1 running = 1'b1;
        for (int c = 0; c < 400 && !halted; c++) @(negedge clk1);
        chk({nm, " halt_reached"}, {31'd0, halted}, 32'd1);
        repeat (3) @(negedge clk1);
        running = 1'b0;
    endtask

    task automatic cmp_state(input string nm);
        for (int k = 1; k < 32; k++) chk($sformatf("%s R%0d", nm, k), dut.Reg[k], m_reg[k]);
        for (int k = 0; k < MD; k++) chk($sformatf("%s Mem[%0d]", nm, k), dut.Mem[k], m_mem[k]);
    endtask

    task automatic run_prog(input string nm);
        int e;
        model_run(e);
        exp_edge = e;
        load_dut();
        go(nm);
        cmp_state(nm);
    endtask

    task automatic prog1();
        clear_state();
        init_mem[0] = ri(ADDI, 1, 0, 16'd10);
        init_mem[1] = ri(ADDI, 2, 0, 16'd20);
        init_mem[2] = ri(ADDI, 3, 0, 16'd25);
        init_mem[3] = rr(OR_, 7, 7, 7);
        init_mem[4] = rr(OR_, 7, 7, 7);
        init_mem[5] = rr(ADD, 4, 1, 2);
        init_mem[6] = rr(OR_, 7, 7, 7);
        init_mem[7] = rr(ADD, 5, 4, 3);
        init_mem[8] = {HLT, 26'd0};
    endtask

    task automatic rand_prog();
        int i, kind;
        clear_state();
        for (int r = 1; r < 8; r++) init_reg[r] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        for (int k = 512; k < 576; k++) init_mem[k] = $urandom;
        for (int k = 24; k < 40; k++) init_mem[k] = {HLT, 26'd0};
        i = 0;
        while (i < 24) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3: init_mem[i] = rr(6'($urandom_range(0, 5)), 5'($urandom_range(0, 7)),
                                            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                4, 5: init_mem[i] = ri(6'($urandom_range(10, 12)), 5'($urandom_range(0, 7)),
                                       5'($urandom_range(0, 7)), 16'($urandom));
                6: if (i < 23) begin
                       init_mem[i] = ri(LW, 5'($urandom_range(0, 7)), 0, 16'(512 + $urandom_range(0, 63)));
                       i++;
                       init_mem[i] = {NOPOP, 26'd0};
                   end else init_mem[i] = {NOPOP, 26'd0};
                7: init_mem[i] = ri(SW, 5'($urandom_range(0, 7)), 0, 16'(512 + $urandom_range(0, 63)));
                8: init_mem[i] = ri(($urandom_range(0, 1) == 0) ? BNEZ : BEQZ, 0,
                                    5'($urandom_range(0, 7)), 16'($urandom_range(0, 3)));
                default: init_mem[i] = {NOPOP, 26'd0};
            endcase
            i++;
        end
    endtask

    initial begin
        load_dut();
        repeat (2) @(negedge clk1);
        chk("reset halted", {31'd0, halted}, 32'd0);
        chk("reset pc", dut.pc, 32'd0);

        prog1();
        run_prog("t1");
        chk("t1 model halt edge", exp_edge, 32'd13);
        chk("t1 R1", dut.Reg[1], 32'd10);
        chk("t1 R4", dut.Reg[4], 32'd30);
        chk("t1 R5", dut.Reg[5], 32'd55);
        #3 rst = 1'b1;
        #1 chk("t1 rst halted", {31'd0, halted}, 32'd0);
        chk("t1 rst pc", dut.pc, 32'd0);

        // reset mid-program without reloading, then re-execute from address 0
        prog1();
        load_dut();
        @(negedge clk1);
        rst = 1'b0;
        edge_cnt = 0;
        #1 running = 1'b1;
        repeat (6) @(posedge clk1);
        #2 running = 1'b0;
        rst = 1'b1;
        #1 chk("mid rst pc", dut.pc, 32'd0);
        chk("mid rst halted", {31'd0, halted}, 32'd0);
        go("mid");
        chk("mid R4", dut.Reg[4], 32'd30);
        chk("mid R5", dut.Reg[5], 32'd55);

        clear_state();
        init_mem[0] = rr(ADD, 1, 0, 0);
        init_mem[1] = ri(ADDI, 1, 1, 16'd5);
        init_mem[2] = ri(ADDI, 2, 1, 16'd1);
        init_mem[3] = {HLT, 26'd0};
        run_prog("t2");
        chk("t2 R2", dut.Reg[2], 32'd6);

        clear_state();
        init_mem[100] = 32'd85;
        init_mem[0] = ri(ADDI, 1, 0, 16'd100);
        init_mem[1] = rr(OR_, 7, 7, 7);
        init_mem[2] = ri(LW, 2, 1, 16'd0);
        init_mem[3] = rr(OR_, 7, 7, 7);
        init_mem[4] = ri(ADDI, 2, 2, 16'd45);
        init_mem[5] = ri(SW, 2, 1, 16'd1);
        init_mem[6] = {HLT, 26'd0};
        run_prog("t3");
        chk("t3 Mem[101]", dut.Mem[101], 32'd130);

        // countdown loop; shadow holds a HLT that must be flushed while the loop is taken
        clear_state();
        init_mem[0] = ri(ADDI, 1, 0, 16'd3);
        init_mem[1] = ri(ADDI, 2, 0, 16'd0);
        init_mem[2] = ri(ADDI, 2, 2, 16'd1);
        init_mem[3] = ri(SUBI, 1, 1, 16'd1);
        init_mem[4] = ri(BNEZ, 0, 1, 16'hFFFD);
        init_mem[5] = {HLT, 26'd0};
        init_mem[6] = ri(ADDI, 6, 0, 16'd99);
        run_prog("loop");
        chk("loop model halt edge", exp_edge, 32'd20);
        chk("loop R1", dut.Reg[1], 32'd0);
        chk("loop R2", dut.Reg[2], 32'd3);
        chk("loop R6", dut.Reg[6], 32'd6);

        clear_state();
        init_mem[0] = ri(ADDI, 1, 0, 16'd7);
        init_mem[1] = ri(ADDI, 2, 0, 16'hFFFA);
        init_mem[2] = rr(OR_, 7, 7, 7);
        init_mem[3] = rr(OR_, 7, 7, 7);
        init_mem[4] = rr(MUL, 3, 1, 2);
        init_mem[5] = {HLT, 26'd0};
        run_prog("mul");
`ifdef MIPS_MUL_EN
        chk("mul R3", dut.Reg[3], 32'hFFFF_FFD6);
`else
        chk("mul R3", dut.Reg[3], 32'd3);
`endif

        for (int t = 0; t < 20; t++) begin
            rand_prog();
            run_prog($sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
